// File: rtl/pattern_scan_fsm_pkg.sv
// pattern_scan_pkg: shared state encoding and sizing helper for the pattern scanner
package pattern_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_HIT  = 3'd2,
    S_MISS = 3'd3,
    S_LOCK = 3'd4,
    S_ISO  = 3'd5
  } state_t;

  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/pattern_scan_fsm_sat_counter.sv
// sat_counter: counter that holds at all-ones, with clear taking priority over increment
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // clear wins; increment stops at all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= clr ? '0 : (inc && !(&count)) ? count + W'(1) : count;

endmodule

// File: rtl/pattern_scan_fsm.sv
// pattern_scan_fsm: bit-serial masked pattern matcher with lock-out prefix, isolation and hit counter
module pattern_scan_fsm
  import pattern_scan_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int LOCK_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] cfg_pattern,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic [LOCK_W-1:0] cfg_lock_pattern,
  input  logic              cfg_lock_en,
  input  logic              unlock,
  input  logic              iso_req,
  input  logic              cnt_clr,
  output logic              detected,
  output logic              miss,
  output logic              locked,
  output logic              isolated,
  output logic [CNT_W-1:0]  hit_count
);

  localparam int IW = idx_w(DATA_W);

  state_t            state, state_n;
  logic [DATA_W-1:0] data_q, pat_q, mask_q, lock_full;
  logic [LOCK_W-1:0] lpat_q;
  logic [IW-1:0]     idx;
  logic              lock_en_q, mis_q, lock_ok_q, ready_q;
  logic              accept, last, in_lock, bit_mis, lock_mis, mis_n, lock_ok_n;

  assign lock_full = DATA_W'(lpat_q) << (DATA_W - LOCK_W);
  assign in_lock   = idx >= IW'(DATA_W - LOCK_W);
  assign bit_mis   = (data_q[idx] ^ pat_q[idx]) & ~mask_q[idx];
  assign lock_mis  = in_lock & (data_q[idx] ^ lock_full[idx]);
  assign mis_n     = mis_q | bit_mis;
  assign lock_ok_n = lock_ok_q & ~lock_mis;
  assign last      = idx == '0;
  assign in_ready  = ready_q & (state == S_IDLE) & ~iso_req;
  assign accept    = in_valid & in_ready;

  // state register; ready_q keeps in_ready low until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= S_IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      ready_q <= 1'b1;
    end

  // next state: scan verdict uses the flags including the final bit-0 compare
  always_comb begin
    state_n = S_IDLE;
    case (state)
      S_IDLE:        state_n = iso_req ? S_ISO : accept ? S_SCAN : S_IDLE;
      S_SCAN:        state_n = iso_req ? S_ISO : !last ? S_SCAN :
                               (lock_en_q && lock_ok_n) ? S_LOCK : mis_n ? S_MISS : S_HIT;
      S_HIT, S_MISS: state_n = iso_req ? S_ISO : S_IDLE;
      S_LOCK:        state_n = unlock ? S_IDLE : S_LOCK;
      S_ISO:         state_n = iso_req ? S_ISO : S_IDLE;
      default:       state_n = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    detected = state == S_HIT;
    miss     = state == S_MISS;
    locked   = state == S_LOCK;
    isolated = state == S_ISO;
  end

  // capture word and config on accept, then walk the index down accumulating sticky flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_q    <= '0;
      pat_q     <= '0;
      mask_q    <= '0;
      lpat_q    <= '0;
      lock_en_q <= 1'b0;
      idx       <= '0;
      mis_q     <= 1'b0;
      lock_ok_q <= 1'b0;
    end else if (accept) begin
      data_q    <= in_data;
      pat_q     <= cfg_pattern;
      mask_q    <= cfg_mask;
      lpat_q    <= cfg_lock_pattern;
      lock_en_q <= cfg_lock_en;
      idx       <= IW'(DATA_W - 1);
      mis_q     <= 1'b0;
      lock_ok_q <= 1'b1;
    end else if (state == S_SCAN) begin
      idx       <= idx - IW'(1);
      mis_q     <= mis_n;
      lock_ok_q <= lock_ok_n;
    end

  sat_counter #(.W(CNT_W)) u_hits (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (state == S_HIT),
    .clr   (cnt_clr),
    .count (hit_count)
  );

endmodule

// File: doc/pattern_scan_fsm.md
Name: pattern_scan_fsm

Overview:
- Parametrised successor to the fixed 12-bit detector FSM.
- Accepts DATA_W-bit words over a valid/ready handshake and scans each word MSB-first, one bit per cycle.
- Compares against a runtime-programmable pattern with per-bit don't-care mask, and flags a configurable lock-out prefix.
- Keeps a saturating hit counter and supports an externally requested isolation mode.

Parameters:
- DATA_W, 12, word width and scan length in bits (>= 2).
- LOCK_W, 4, lock-prefix width; compared against word bits [DATA_W-1 -: LOCK_W] (1 <= LOCK_W <= DATA_W).
- CNT_W, 8, hit-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  word offered.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_W  word to scan.
- cfg_pattern  in  DATA_W  expected bit values.
- cfg_mask  in  DATA_W  1 = don't-care bit.
- cfg_lock_pattern  in  LOCK_W  lock-out prefix.
- cfg_lock_en  in  1  enables lock-out detection.
- unlock  in  1  leaves LOCK.
- iso_req  in  1  isolation request (level).
- cnt_clr  in  1  synchronous clear of hit_count.
- detected  out  1  one-cycle pulse, word matched.
- miss  out  1  one-cycle pulse, word did not match.
- locked  out  1  high while in LOCK.
- isolated  out  1  high while in ISO.
- hit_count  out  CNT_W  saturating count of detected pulses.

Behaviour:
- Reset (async assert, sync deassert):
  - State goes to IDLE and all capture registers clear.
  - Outputs reset to: in_ready=0, detected=0, miss=0, locked=0, isolated=0, hit_count=0.
  - Reset mid-scan or mid-LOCK aborts with no result pulse.
- States: IDLE, SCAN, HIT, MISS, LOCK, ISO.
- in_ready = 1 only in IDLE with iso_req=0. A word is accepted when in_valid && in_ready.
- Accept cycle captures in_data, cfg_pattern, cfg_mask, cfg_lock_pattern and cfg_lock_en, then moves to SCAN with bit index = DATA_W-1. Config changes during a scan have no effect.
- SCAN, each cycle:
  - Compare bit idx. A mismatch on an unmasked bit sets a sticky mis flag.
  - While idx >= DATA_W-LOCK_W, compare against the lock prefix and clear a sticky lock_ok flag on mismatch.
  - idx decrements each cycle.
- Scan always runs the full DATA_W cycles: fixed latency, no early abort on mismatch.
- After the bit-0 cycle, exit SCAN in priority order:
  - LOCK if lock_en && lock_ok.
  - else MISS if mis.
  - else HIT.
- HIT: detected=1 for exactly one cycle; hit_count increments unless already at all-ones; next state IDLE.
- MISS: miss=1 for exactly one cycle; next state IDLE.
- Latency: result pulse appears DATA_W+1 cycles after the accept edge. Minimum spacing between accepts is DATA_W+2 cycles.
- LOCK:
  - locked=1, in_ready=0, no pulses.
  - Leaves to IDLE on the cycle after unlock=1 is sampled.
  - iso_req is ignored while in LOCK.
- ISO:
  - Entered from IDLE, SCAN, HIT or MISS whenever iso_req=1; the in-flight word is dropped with no pulse.
  - isolated=1 while in ISO.
  - Returns to IDLE the cycle after iso_req is sampled 0.
- cnt_clr:
  - Zeroes hit_count next cycle.
  - If cnt_clr and a HIT coincide, the result is 0 (clear wins).
- Mask all-ones: every non-locked word produces HIT.
- Illegal state encoding recovers to IDLE.

Decomposition:
- Shared package pattern_scan_pkg holds:
  - the state enum (logic [2:0]);
  - a localparam function for index width, $clog2(DATA_W).
- One sub-module, sat_counter (CNT_W, inc, clr, count), reusable for other counters in the codebase.
- FSM, datapath capture and compare stay in pattern_scan_fsm.

Test Plan:
- Basic hit: DATA_W=12, pattern 0x179, mask 0x000, lock_en=0, send 0x179 -> detected pulse exactly 13 cycles after accept, hit_count=1, in_ready back to 1 the next cycle.
- Miss and mask: send 0x178 -> miss pulse at cycle 13, no detected. Then mask 0x001 with 0x178 -> detected, hit_count=2.
- Lock-out: lock_pattern 0xE, lock_en=1, send 0xE00 -> locked=1 after 13 cycles, in_ready=0 and iso_req ignored. Pulse unlock -> IDLE next cycle, locked=0.
- Isolation mid-scan: accept 0x179, raise iso_req at cycle 5 -> isolated=1, no detected ever. Drop iso_req -> IDLE, then 0x179 detects normally.
- Counter: CNT_W=2, four consecutive hits -> hit_count 1,2,3,3. cnt_clr coinciding with a hit -> 0.
- Reset mid-scan: assert rst_n=0 at cycle 6 of a scan -> all outputs 0 immediately, no pulse, in_ready=1 one cycle after release.
